vga_pixel_writer: RTL and testbench

Receiving end of the drawer-to-VGA pixel stream. Sprite and screen drawers emit one (x, y, colour) triple per cycle with a plot strobe. This block clips each pixel to the screen and translates it to a linear framebuffer address. It then queues the write in a FIFO and drains it into the framebuffer write port under a ready handshake. It also gives drawers back-pressure (`ready`) and a flush/done handshake, so the drawer FSM knows when its last pixel is in memory.

---
 rtl/vga_pixel_writer.sv | 187 ++++++++++++++++++
 tb/tb_vga_pixel_writer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_writer.sv
// vga_pixel_writer
//   Receives the drawer pixel stream (x, y, colour + plot strobe), drops
//   pixels that fall outside the screen, converts the survivors to a linear
//   framebuffer address (y*WIDTH + x), queues them in a FIFO and drains the
//   FIFO into the framebuffer write port under a mem_ready handshake.
//   A flush/done handshake tells the drawer when every accepted pixel has
//   reached memory.
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-high; clears all state
//   plot         pixel valid from drawer
//   x, y         pixel column / row
//   colour       3/3/3 RGB pixel colour
//   ready        block can accept a pixel this cycle
//   flush        one-cycle request for a done indication
//   done         one-cycle pulse answering flush
//   mem_address  framebuffer write address (FIFO head)
//   mem_data     framebuffer write data (FIFO head)
//   mem_wren     write request, high while the FIFO holds entries
//   mem_ready    framebuffer accepts the write this cycle
//   pixel_count  pixels written to memory since reset (wraps)
//   overflow     sticky: a plot arrived while ready was low
module vga_pixel_writer #(
  parameter int unsigned WIDTH  = 160,
  parameter int unsigned HEIGHT = 120,
  parameter int unsigned DEPTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        plot,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  input  logic [8:0]  colour,
  output logic        ready,
  input  logic        flush,
  output logic        done,
  output logic [14:0] mem_address,
  output logic [8:0]  mem_data,
  output logic        mem_wren,
  input  logic        mem_ready,
  output logic [15:0] pixel_count,
  output logic        overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  // ---------------------------------------------------------------
  // S1: capture + clip
  // ---------------------------------------------------------------
  logic [7:0] x1;
  logic [6:0] y1;
  logic [8:0] c1;
  logic       v1;
  logic       in_range;

  assign in_range = (32'(x) < WIDTH) && (32'(y) < HEIGHT);

  always_ff @(posedge clk) begin
    if (reset) begin
      x1 <= '0;
      y1 <= '0;
      c1 <= '0;
      v1 <= 1'b0;
    end else begin
      x1 <= x;
      y1 <= y;
      c1 <= colour;
      v1 <= plot & ready & in_range;
    end
  end

  // ---------------------------------------------------------------
  // S2: linear address
  // ---------------------------------------------------------------
  logic [14:0] a2;
  logic [8:0]  c2;
  logic        v2;

  always_ff @(posedge clk) begin
    if (reset) begin
      a2 <= '0;
      c2 <= '0;
      v2 <= 1'b0;
    end else begin
      a2 <= 15'(y1) * 15'(WIDTH) + 15'(x1);
      c2 <= c1;
      v2 <= v1;
    end
  end

  // ---------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------
  logic [14:0] fifo_addr [DEPTH];
  logic [8:0]  fifo_col  [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_count;
  logic          push;
  logic          pop;

  // Pushes are never refused: ready already reserves room for both
  // in-flight stages, so v2 always finds a free slot (or a same-cycle pop).
  assign push = v2;
  assign pop  = mem_wren & mem_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= a2;
      fifo_col[wr_ptr]  <= c2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Back-pressure and drain outputs
  // ---------------------------------------------------------------
  logic [OW-1:0] occupancy;

  assign occupancy = OW'(fifo_count) + OW'(v1) + OW'(v2);
  assign ready     = occupancy < OW'(DEPTH);

  assign mem_wren = (fifo_count != '0);
  // Head is forced to zero when empty so the port idles at a known value
  // (the storage array itself is not reset).
  assign mem_address = mem_wren ? fifo_addr[rd_ptr] : '0;
  assign mem_data    = mem_wren ? fifo_col[rd_ptr]  : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (pop) pixel_count <= pixel_count + 1'b1;
      if (plot && !ready) overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------
  // Flush / done FSM
  // ---------------------------------------------------------------
  state_t state;
  state_t state_n;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    done    = 1'b0;
    unique case (state)
      ST_IDLE: if (flush) state_n = ST_WAIT;
      ST_WAIT: if (!v1 && !v2 && (fifo_count == '0)) state_n = ST_DONE;
      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vga_pixel_writer.sv
// Self-checking bench for vga_pixel_writer: queue-based reference model
// stepped on every rising edge, per-cycle comparison on the falling edge,
// plus directed scenarios with hand-computed expectations.
module tb_vga_pixel_writer;
  localparam int W = 160;
  localparam int H = 120;
  localparam int D = 16;

  logic        clk = 1'b0;
  logic        reset, plot, flush, mem_ready;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [8:0]  colour;
  logic        ready, done, mem_wren, overflow;
  logic [14:0] mem_address;
  logic [8:0]  mem_data;
  logic [15:0] pixel_count;

  always #5 clk = ~clk;

  vga_pixel_writer #(.WIDTH(W), .HEIGHT(H), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .plot(plot), .x(x), .y(y), .colour(colour),
    .ready(ready), .flush(flush), .done(done), .mem_address(mem_address),
    .mem_data(mem_data), .mem_wren(mem_wren), .mem_ready(mem_ready),
    .pixel_count(pixel_count), .overflow(overflow)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int addr; int col; } pix_t;
  pix_t m_fifo[$];
  pix_t m_s1, m_s2;
  bit   m_s1v, m_s2v;
  int   m_count;
  bit   m_ovf;
  bit   m_waiting, m_done;

  bit   chk_en = 1'b0;
  int   cyc = 0;
  int   last_wr = 0;
  int   dut_log[$];

  int   occ_e;
  bit   rdy_e, empty_e, was_wait, was_done;

  always @(posedge clk) begin
    cyc++;
    if (chk_en && mem_wren === 1'b1 && mem_ready === 1'b1) begin
      dut_log.push_back(int'(mem_address));
      last_wr = cyc;
    end
    if (reset) begin
      m_fifo.delete();
      m_s1v = 0; m_s2v = 0;
      m_count = 0; m_ovf = 0;
      m_waiting = 0; m_done = 0;
    end else begin
      occ_e    = m_fifo.size() + int'(m_s1v) + int'(m_s2v);
      rdy_e    = occ_e < D;
      empty_e  = occ_e == 0;
      was_wait = m_waiting;
      was_done = m_done;
      if (m_fifo.size() > 0 && mem_ready) begin
        void'(m_fifo.pop_front());
        m_count = (m_count + 1) % 65536;
      end
      if (m_s2v) m_fifo.push_back(m_s2);
      m_s2v = m_s1v;
      m_s2  = m_s1;
      m_s1v = plot && rdy_e && (int'(x) < W) && (int'(y) < H);
      m_s1.addr = int'(y) * W + int'(x);
      m_s1.col  = int'(colour);
      if (plot && !rdy_e) m_ovf = 1;
      m_done    = was_wait && empty_e;
      m_waiting = (was_wait && !empty_e) || (!was_wait && !was_done && flush);
    end
  end

  // ---------------- per-cycle compare ----------------
  int occ_c;
  int done_pulses = 0;
  int done_cyc = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      occ_c = m_fifo.size() + int'(m_s1v) + int'(m_s2v);
      check("ready", ready, occ_c < D);
      check("mem_wren", mem_wren, m_fifo.size() != 0);
      if (m_fifo.size() != 0) begin
        check("mem_address", mem_address, m_fifo[0].addr);
        check("mem_data", mem_data, m_fifo[0].col);
      end
      check("pixel_count", pixel_count, m_count);
      check("overflow", overflow, m_ovf);
      check("done", done, m_done);
      if (done === 1'b1) begin
        done_pulses++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; plot = 1'b0; flush = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int idle;
    idle = 0;
    for (int n = 0; n < max_cyc && idle < 3; n++) begin
      step();
      if (mem_wren === 1'b0) idle++;
      else idle = 0;
    end
    check("drain_timeout", idle >= 3, 1);
  endtask

  task automatic drive_pix(input int px, input int py, input int pc);
    x = 8'(px); y = 7'(py); colour = 9'(pc); plot = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, acc, mism, i, n, k;
    bit rd;
    reset = 1'b1; plot = 1'b0; flush = 1'b0; mem_ready = 1'b0;
    x = '0; y = '0; colour = '0;
    @(negedge clk);
    do_reset();

    // reset values
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_wren", mem_wren, 0);
    check("rst_addr", mem_address, 0);
    check("rst_data", mem_data, 0);
    check("rst_count", pixel_count, 0);
    check("rst_ovf", overflow, 0);

    // single pixel
    mem_ready = 1'b1;
    drive_pix(39, 39, 'h1FF);
    step();
    plot = 1'b0;
    lat = 1;
    while (mem_wren !== 1'b1 && lat < 20) begin step(); lat++; end
    check("single_latency", lat, 3);
    check("single_addr", mem_address, 6279);
    check("single_data", mem_data, 'h1FF);
    step();
    check("single_count", pixel_count, 1);
    check("single_wren_off", mem_wren, 0);

    // clipping
    do_reset();
    dut_log.delete();
    mem_ready = 1'b1;
    drive_pix(160, 0, 1);   step();
    drive_pix(0, 120, 2);   step();
    drive_pix(159, 119, 3); step();
    plot = 1'b0;
    drain(20);
    check("clip_writes", dut_log.size(), 1);
    if (dut_log.size() > 0) check("clip_addr", dut_log[0], 19199);
    check("clip_ovf", overflow, 0);
    check("clip_count", pixel_count, 1);

    // back-pressure
    do_reset();
    dut_log.delete();
    mem_ready = 1'b0;
    acc = 0;
    for (int j = 0; j < 20; j++) begin
      drive_pix(j, 5, j);
      if (ready === 1'b1) acc++;
      step();
    end
    plot = 1'b0;
    check("bp_accepted", acc, 16);
    check("bp_ready_low", ready, 0);
    check("bp_ovf", overflow, 1);
    mem_ready = 1'b1;
    drain(60);
    check("bp_writes", dut_log.size(), 16);
    mism = 0;
    for (int j = 0; j < 16 && j < dut_log.size(); j++)
      if (dut_log[j] != 5 * 160 + j) mism++;
    check("bp_order", mism, 0);

    // 80x40 sprite at (39,39), mem_ready random
    do_reset();
    dut_log.delete();
    i = 0; n = 0;
    while (i < 3200 && n < 20000) begin
      mem_ready = 1'($urandom_range(0, 1));
      drive_pix(39 + i % 80, 39 + i / 80, int'($urandom_range(0, 511)));
      rd = (ready === 1'b1);
      step();
      if (rd) i++;
      n++;
    end
    plot = 1'b0;
    mem_ready = 1'b1;
    check("sprite_sent", i, 3200);
    drain(200);
    check("sprite_writes", dut_log.size(), 3200);
    mism = 0;
    for (int j = 0; j < dut_log.size(); j++)
      if (dut_log[j] != (39 + j / 80) * 160 + 39 + j % 80) mism++;
    check("sprite_order", mism, 0);
    check("sprite_count", pixel_count, 3200);

    // random traffic with clipping, stalls and stray flushes
    do_reset();
    for (int j = 0; j < 400; j++) begin
      plot      = ($urandom_range(0, 2) != 0);
      x         = 8'($urandom_range(0, 200));
      y         = 7'($urandom_range(0, 127));
      colour    = 9'($urandom_range(0, 511));
      mem_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      step();
    end
    plot = 1'b0; flush = 1'b0; mem_ready = 1'b1;
    drain(100);

    // flush on last plot of a 5-pixel burst; second flush during WAIT ignored
    do_reset();
    mem_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      drive_pix(10 + j, 3, j);
      flush = (j == 4);
      step();
    end
    plot = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    done_pulses = 0;
    for (int j = 0; j < 20; j++) step();
    check("flush_pulses", done_pulses, 1);
    check("flush_timing", done_cyc, last_wr + 1);

    // flush while idle
    flush = 1'b1;
    step();
    flush = 1'b0;
    k = 1;
    while (done !== 1'b1 && k < 10) begin step(); k++; end
    check("idle_flush_lat", k, 2);
    step();
    check("idle_flush_off", done, 0);

    // reset with 8 entries queued and overflow set
    do_reset();
    mem_ready = 1'b0;
    for (int j = 0; j < 20; j++) begin
      drive_pix(j, 7, j);
      step();
    end
    plot = 1'b0;
    mem_ready = 1'b1;
    for (int j = 0; j < 8; j++) step();
    mem_ready = 1'b0;
    check("pre_rst_count", pixel_count, 8);
    check("pre_rst_ovf", overflow, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_wren", mem_wren, 0);
    check("mid_rst_ready", ready, 1);
    check("mid_rst_count", pixel_count, 0);
    check("mid_rst_ovf", overflow, 0);
    dut_log.delete();
    mem_ready = 1'b1;
    for (int j = 0; j < 5; j++) step();
    check("mid_rst_no_writes", dut_log.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
